bus_arb2: RTL and testbench

Two-master, one-slave bus arbiter for the kerygma SoC shared data bus. It shares the memory/CSR slave port between the CPU data port (master 0) and the UDM debug bus master (master 1). Arbitration is round-robin. The block tracks outstanding reads in an owner-tag FIFO so that in-order slave responses return to the master that issued them. Handshakes are req/ack for commands and single-cycle resp pulses for read data, with zero added latency on either path.

---
 rtl/bus_arb2.sv | 187 ++++++++++++++++++
 tb/tb_bus_arb2.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter for one slave; BUS_ARB_UDM_PRIORITY_EN gives m1 fixed priority.
// Latency: zero added cycles on the command and response paths (purely combinational muxing).
// Backpressure: owner holds until s_ack_i; s_req_o is held low while the read-tag FIFO is full and not popping.

module bus_arb2_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push_vld,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop_vld,
    output logic [W-1:0]               o_head_dat,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (i_push_vld) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Push and pop together keep the count, which is what lets a full FIFO accept in its pop cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push_vld) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop_vld)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push_vld, i_pop_vld})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

module bus_arb2 #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    output logic                m0_ack_o,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_bi,
    input  logic [DATA_W/8-1:0] m0_be_bi,
    input  logic [DATA_W-1:0]   m0_wdata_bi,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_bo,
    input  logic                m1_req_i,
    output logic                m1_ack_o,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_bi,
    input  logic [DATA_W/8-1:0] m1_be_bi,
    input  logic [DATA_W-1:0]   m1_wdata_bi,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_bo,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_bo,
    output logic [DATA_W/8-1:0] s_be_bo,
    output logic [DATA_W-1:0]   s_wdata_bo,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_bi
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(RESP_FIFO_DEPTH) + 1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t r_state;
    logic   r_owner;
    logic   r_last_grant;
    logic   r_orphan_resp;

    logic             w_live;
    logic             w_pick;
    logic             w_owner;
    logic             w_owner_req;
    logic             w_owner_we;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_stall;
    logic             w_s_req;
    logic             w_accept;
    logic             w_push;
    logic [0:0]       w_head;
    logic [CNT_W-1:0] w_fifo_count;

    assign w_live = ~rst_i;

    always_comb begin
        w_pick = 1'b0;
        if (m0_req_i && m1_req_i) begin
`ifdef BUS_ARB_UDM_PRIORITY_EN
            w_pick = 1'b1;
`else
            w_pick = ~r_last_grant;
`endif
        end else if (m1_req_i) begin
            w_pick = 1'b1;
        end
    end

    // A waiting command keeps its registered owner so the grant cannot move before the ack.
    assign w_owner      = (r_state == ST_LOCKED) ? r_owner : w_pick;
    assign w_owner_req  = w_owner ? m1_req_i : m0_req_i;
    assign w_owner_we   = w_owner ? m1_we_i  : m0_we_i;

    assign w_fifo_full  = (w_fifo_count == CNT_W'(RESP_FIFO_DEPTH));
    assign w_fifo_empty = (w_fifo_count == '0);
    assign w_pop        = s_resp_i & ~w_fifo_empty & w_live;
    assign w_stall      = w_fifo_full & ~w_pop;
    assign w_s_req      = w_owner_req & ~w_stall & w_live;
    assign w_accept     = w_s_req & s_ack_i;
    assign w_push       = w_accept & ~w_owner_we;

    assign s_req_o    = w_s_req;
    assign s_we_o     = w_owner_we & w_live;
    assign s_addr_bo  = {ADDR_W{w_live}} & (w_owner ? m1_addr_bi  : m0_addr_bi);
    assign s_be_bo    = {BE_W{w_live}}   & (w_owner ? m1_be_bi    : m0_be_bi);
    assign s_wdata_bo = {DATA_W{w_live}} & (w_owner ? m1_wdata_bi : m0_wdata_bi);

    assign m0_ack_o = w_accept & ~w_owner;
    assign m1_ack_o = w_accept &  w_owner;

    assign m0_resp_o   = w_pop & ~w_head[0];
    assign m1_resp_o   = w_pop &  w_head[0];
    assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
    assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

    bus_arb2_fifo #(
        .W     (1),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_tag_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_push_vld (w_push),
        .i_push_dat (w_owner),
        .i_pop_vld  (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_orphan_resp <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_s_req && !s_ack_i) begin
                        r_state <= ST_LOCKED;
                        r_owner <= w_pick;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) r_last_grant <= w_owner;
            if (s_resp_i && w_fifo_empty) r_orphan_resp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_arb2.sv
// Bench for bus_arb2: scenario tasks drive a scripted slave; read responses are scored against a queue.
module tb_bus_arb2;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_ack_o, m0_we_i, m0_resp_o;
    logic [31:0] m0_addr_bi, m0_wdata_bi, m0_rdata_bo;
    logic [3:0]  m0_be_bi;
    logic        m1_req_i, m1_ack_o, m1_we_i, m1_resp_o;
    logic [31:0] m1_addr_bi, m1_wdata_bi, m1_rdata_bo;
    logic [3:0]  m1_be_bi;
    logic        s_req_o, s_we_o, s_ack_i, s_resp_i;
    logic [31:0] s_addr_bo, s_wdata_bo, s_rdata_bi;
    logic [3:0]  s_be_bo;

    typedef struct packed {
        logic        id;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    bus_arb2 dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_ack_o(m0_ack_o), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi),
        .m0_be_bi(m0_be_bi), .m0_wdata_bi(m0_wdata_bi), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
        .m1_req_i(m1_req_i), .m1_ack_o(m1_ack_o), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi),
        .m1_be_bi(m1_be_bi), .m1_wdata_bi(m1_wdata_bi), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
        .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    // Response scoreboard: every resp pulse must match the oldest expected (master, data).
    always @(negedge clk) begin
        exp_t e;
        logic        got_id;
        logic [31:0] got_dat;
        if (!rst_i && s_resp_i) begin
            n_total++;
            if ((!m0_resp_o && m0_rdata_bo !== 32'h0) || (!m1_resp_o && m1_rdata_bo !== 32'h0)) begin
                $display("FAIL rdata_idle_zero: m0_rdata=%h m1_rdata=%h, required 0 on idle master",
                         m0_rdata_bo, m1_rdata_bo);
            end else begin
                n_pass++;
            end
        end
        if (!rst_i && (m0_resp_o || m1_resp_o)) begin
            n_total++;
            got_id  = m1_resp_o;
            got_dat = m1_resp_o ? m1_rdata_bo : m0_rdata_bo;
            if (sb.size() == 0) begin
                $display("FAIL resp_unexpected: m%0d got %h, required no response", got_id, got_dat);
            end else begin
                e = sb.pop_front();
                if ((m0_resp_o && m1_resp_o) || got_id !== e.id || got_dat !== e.dat)
                    $display("FAIL resp_route: m0_resp=%b m1_resp=%b data=%h, required m%0d data %h",
                             m0_resp_o, m1_resp_o, got_dat, e.id, e.dat);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        m0_req_i = 0; m0_we_i = 0; m0_addr_bi = 0; m0_be_bi = 4'hF; m0_wdata_bi = 0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_bi = 0; m1_be_bi = 4'hF; m1_wdata_bi = 0;
        s_ack_i = 0; s_resp_i = 0; s_rdata_bi = 0;
    endtask

    task automatic do_reset;
        tick; idle_inputs(); rst_i = 1;
        tick; rst_i = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_i = 1; m0_req_i = 1; m1_req_i = 1; m0_addr_bi = 32'hFFFF_0000; s_ack_i = 1; s_resp_i = 1;
        s_rdata_bi = 32'h1234_5678;
        tick; tick; smp;
        n_total++;
        if ({s_req_o, s_we_o, m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o} !== 6'b0 || s_addr_bo !== 32'h0 ||
            m0_rdata_bo !== 32'h0 || m1_rdata_bo !== 32'h0)
            $display("FAIL reset_outputs: s_req=%b ack=%b%b resp=%b%b addr=%h, required all zero",
                     s_req_o, m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o, s_addr_bo);
        else n_pass++;
        tick; idle_inputs();
        tick; rst_i = 0;
        smp;
        n_total++;
        if (dut.r_last_grant !== 1'b1 || dut.w_fifo_count !== 3'd0 || dut.r_orphan_resp !== 1'b0 || s_req_o !== 1'b0)
            $display("FAIL reset_state: last_grant=%b count=%0d orphan=%b s_req=%b, required 1/0/0/0",
                     dut.r_last_grant, dut.w_fifo_count, dut.r_orphan_resp, s_req_o);
        else n_pass++;
    endtask

    task automatic test_single_read;
        tick; m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h0000_0010; s_ack_i = 0;
        smp;
        n_total++;
        if (s_req_o !== 1'b1 || s_addr_bo !== 32'h10 || s_we_o !== 1'b0 || m0_ack_o !== 1'b0)
            $display("FAIL single_wait: s_req=%b addr=%h ack=%b, required 1/00000010/0", s_req_o, s_addr_bo, m0_ack_o);
        else n_pass++;
        tick; s_ack_i = 1;
        smp;
        n_total++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0)
            $display("FAIL single_ack: m0_ack=%b m1_ack=%b, required 1/0", m0_ack_o, m1_ack_o);
        else n_pass++;
        sb.push_back('{id: 1'b0, dat: 32'hDEAD_BEEF});
        tick; m0_req_i = 0; s_ack_i = 0;
        smp;
        n_total++;
        if (m0_ack_o !== 1'b0 || s_req_o !== 1'b0)
            $display("FAIL single_ack_once: m0_ack=%b s_req=%b, required 0/0", m0_ack_o, s_req_o);
        else n_pass++;
        tick; tick;
        tick; s_resp_i = 1; s_rdata_bi = 32'hDEAD_BEEF;
        smp;
        n_total++;
        if (m1_resp_o !== 1'b0 || m0_resp_o !== 1'b1)
            $display("FAIL single_resp: m0_resp=%b m1_resp=%b, required 1/0", m0_resp_o, m1_resp_o);
        else n_pass++;
        tick; s_resp_i = 0; s_rdata_bi = 0;
    endtask

    task automatic test_tie;
        logic e;
        do_reset();
        m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h100; m0_wdata_bi = 32'hA0A0;
        m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h200; m1_wdata_bi = 32'hB1B1;
        s_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef BUS_ARB_UDM_PRIORITY_EN
            e = 1'b1;
`else
            e = (i % 2 == 1);
`endif
            smp;
            n_total++;
            if (m0_ack_o !== ~e || m1_ack_o !== e || s_addr_bo !== (e ? 32'h200 : 32'h100) ||
                s_wdata_bo !== (e ? 32'hB1B1 : 32'hA0A0))
                $display("FAIL tie_grant_%0d: ack=%b%b addr=%h, required m%0d", i, m1_ack_o, m0_ack_o, s_addr_bo, e);
            else n_pass++;
            tick;
        end
        idle_inputs();
    endtask

    task automatic test_lock;
        // Leave last_grant at m0 so a non-locked arbiter would hand a tie to m1.
        m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h300; s_ack_i = 1;
        smp;
        n_total++;
        if (m0_ack_o !== 1'b1) $display("FAIL lock_prelude: m0_ack=%b, required 1", m0_ack_o);
        else n_pass++;
        for (int c = 1; c <= 6; c++) begin
            tick;
            if (c == 1) begin m0_addr_bi = 32'h400; s_ack_i = 0; end
            if (c == 2) begin m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h500; end
            if (c == 6) s_ack_i = 1;
            smp;
            n_total++;
            if (c < 6) begin
                if (s_addr_bo !== 32'h400 || s_req_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0)
                    $display("FAIL lock_hold_%0d: addr=%h ack=%b%b, required 00000400 and no ack", c, s_addr_bo, m1_ack_o, m0_ack_o);
                else n_pass++;
            end else begin
                if (s_addr_bo !== 32'h400 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0)
                    $display("FAIL lock_release: addr=%h ack=%b%b, required m0 ack", s_addr_bo, m1_ack_o, m0_ack_o);
                else n_pass++;
            end
        end
        tick; m0_req_i = 0;
        smp;
        n_total++;
        if (m1_ack_o !== 1'b1 || s_addr_bo !== 32'h500)
            $display("FAIL lock_next_grant: m1_ack=%b addr=%h, required 1/00000500", m1_ack_o, s_addr_bo);
        else n_pass++;
        tick; idle_inputs();
    endtask

    task automatic test_interleaved_reads;
        logic id;
        for (int i = 0; i < 4; i++) begin
            id = (i % 2 == 1);
            tick;
            m0_req_i = ~id; m0_we_i = 0; m0_addr_bi = 32'h1000 + 32'(i * 4);
            m1_req_i = id;  m1_we_i = 0; m1_addr_bi = 32'h2000 + 32'(i * 4);
            s_ack_i = 1;
            smp;
            n_total++;
            if (m0_ack_o !== ~id || m1_ack_o !== id)
                $display("FAIL ilv_accept_%0d: ack=%b%b, required m%0d", i, m1_ack_o, m0_ack_o, id);
            else n_pass++;
            sb.push_back('{id: id, dat: 32'(i + 1)});
        end
        tick; idle_inputs();
        smp;
        n_total++;
        if (dut.w_fifo_count !== 3'd4) $display("FAIL ilv_count: count=%0d, required 4", dut.w_fifo_count);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick; s_resp_i = 1; s_rdata_bi = 32'(i + 1);
            smp;
        end
        tick; s_resp_i = 0; s_rdata_bi = 0;
        smp;
        n_total++;
        if (dut.w_fifo_count !== 3'd0) $display("FAIL ilv_drain: count=%0d, required 0", dut.w_fifo_count);
        else n_pass++;
    endtask

    task automatic test_fifo_full;
        for (int i = 0; i < 4; i++) begin
            tick; m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h3000 + 32'(i * 4); s_ack_i = 1;
            smp;
            n_total++;
            if (m0_ack_o !== 1'b1) $display("FAIL full_fill_%0d: m0_ack=%b, required 1", i, m0_ack_o);
            else n_pass++;
            sb.push_back('{id: 1'b0, dat: 32'hA0 + 32'(i)});
        end
        tick; m0_addr_bi = 32'h3010;
        for (int c = 0; c < 2; c++) begin
            smp;
            n_total++;
            if (s_req_o !== 1'b0 || m0_ack_o !== 1'b0)
                $display("FAIL full_stall_%0d: s_req=%b m0_ack=%b, required 0/0", c, s_req_o, m0_ack_o);
            else n_pass++;
            tick;
        end
        s_resp_i = 1; s_rdata_bi = 32'hA0;
        smp;
        n_total++;
        if (s_req_o !== 1'b1 || m0_ack_o !== 1'b1)
            $display("FAIL full_pop_accept: s_req=%b m0_ack=%b, required 1/1", s_req_o, m0_ack_o);
        else n_pass++;
        sb.push_back('{id: 1'b0, dat: 32'hA4});
        tick; m0_req_i = 0; s_ack_i = 0; s_resp_i = 0;
        smp;
        n_total++;
        if (dut.w_fifo_count !== 3'd4) $display("FAIL full_count: count=%0d, required 4", dut.w_fifo_count);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick; s_resp_i = 1; s_rdata_bi = 32'hA1 + 32'(i);
            smp;
        end
        tick; s_resp_i = 0; s_rdata_bi = 0;
    endtask

    task automatic test_reset_mid;
        tick; m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h4000; s_ack_i = 1;
        tick; m0_req_i = 0; m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h5000;
        tick; idle_inputs();
        smp;
        n_total++;
        if (dut.w_fifo_count !== 3'd2) $display("FAIL mid_pending: count=%0d, required 2", dut.w_fifo_count);
        else n_pass++;
        tick; rst_i = 1;
        tick; rst_i = 0;
        smp;
        n_total++;
        if (dut.w_fifo_count !== 3'd0 || dut.r_orphan_resp !== 1'b0)
            $display("FAIL mid_flush: count=%0d orphan=%b, required 0/0", dut.w_fifo_count, dut.r_orphan_resp);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick; s_resp_i = 1; s_rdata_bi = 32'h55 + 32'(i);
            smp;
            n_total++;
            if (m0_resp_o !== 1'b0 || m1_resp_o !== 1'b0)
                $display("FAIL mid_orphan_resp_%0d: resp=%b%b, required 00", i, m1_resp_o, m0_resp_o);
            else n_pass++;
        end
        tick; s_resp_i = 0; s_rdata_bi = 0;
        smp;
        n_total++;
        if (dut.r_orphan_resp !== 1'b1 || dut.w_fifo_count !== 3'd0)
            $display("FAIL mid_orphan_flag: orphan=%b count=%0d, required 1/0", dut.r_orphan_resp, dut.w_fifo_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_lock();
        test_interleaved_reads();
        test_fifo_full();
        test_reset_mid();
        tick;
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_empty: %0d responses outstanding, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
